// File: rtl/mult_dispatcher_pkg.sv
// mult_dispatcher_pkg: shared state encoding, default sizing and timeout width helper
package mult_dispatcher_pkg;
  localparam int SIZE_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int TIMEOUT_DEF = 255;
  typedef enum logic [2:0] {IDLE, INIT, START, WAIT, CAPTURE} state_t;
  function automatic int tcnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/mult_dispatcher_sync_fifo.sv
// sync_fifo: single-clock circular FIFO with occupancy count; push on full and pop on empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign w_push = push && !full;
  assign w_pop = pop && !empty;
  assign dout = r_mem[r_rp];
  assign full = r_cnt == CW'(DEPTH);
  assign empty = r_cnt == '0;
  assign count = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/mult_dispatcher.sv
// mult_dispatcher: queues operand pairs, runs each through the start/done core, queues results
module mult_dispatcher import mult_dispatcher_pkg::*; #(
  parameter int SIZE = SIZE_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_a,
  input  logic [SIZE-1:0] in_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [SIZE-1:0] res_data,
  output logic            unit_rst_begin,
  output logic            unit_start,
  output logic [SIZE-1:0] unit_a,
  output logic [SIZE-1:0] unit_b,
  input  logic            unit_done,
  input  logic [SIZE-1:0] unit_out,
  output logic            busy,
  output logic            timeout_err,
  output logic [15:0]     jobs_done
);
  localparam int TW = tcnt_width(TIMEOUT);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t r_state;
  logic [TW-1:0] r_tcnt;
  logic [SIZE-1:0] r_a, r_b;
  logic r_rst_begin, r_start, r_terr;
  logic [15:0] r_jobs;
  logic w_op_full, w_op_empty, w_res_full, w_res_empty, w_issue, w_capture, w_unused;
  logic [2*SIZE-1:0] w_op_dout;
  logic [CW-1:0] w_op_count, w_res_count;
  // A free result slot is reserved at issue, so the capture push can never overflow
  assign w_issue = r_state == IDLE && !w_op_empty && w_res_count < CW'(DEPTH);
  assign w_capture = r_state == WAIT && unit_done;
  assign w_unused = ^{w_op_count, w_res_full};
  assign in_ready = !w_op_full;
  assign res_valid = !w_res_empty;
  assign unit_rst_begin = r_rst_begin;
  assign unit_start = r_start;
  assign unit_a = r_a;
  assign unit_b = r_b;
  assign busy = r_state != IDLE;
  assign timeout_err = r_terr;
  assign jobs_done = r_jobs;
  sync_fifo #(.WIDTH(2*SIZE), .DEPTH(DEPTH)) u_op_fifo (
    .clk(clk), .rst(rst), .push(in_valid && in_ready), .pop(w_issue),
    .din({in_a, in_b}), .dout(w_op_dout), .full(w_op_full), .empty(w_op_empty), .count(w_op_count)
  );
  sync_fifo #(.WIDTH(SIZE), .DEPTH(DEPTH)) u_res_fifo (
    .clk(clk), .rst(rst), .push(w_capture), .pop(res_valid && res_ready),
    .din(unit_out), .dout(res_data), .full(w_res_full), .empty(w_res_empty), .count(w_res_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tcnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_rst_begin <= 1'b0;
      r_start <= 1'b0;
      r_terr <= 1'b0;
      r_jobs <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_issue) begin
          r_a <= w_op_dout[2*SIZE-1:SIZE];
          r_b <= w_op_dout[SIZE-1:0];
          r_rst_begin <= 1'b1;
          r_state <= INIT;
        end
        INIT: begin
          r_rst_begin <= 1'b0;
          r_start <= 1'b1;
          r_state <= START;
        end
        START: begin
          r_start <= 1'b0;
          r_tcnt <= '0;
          r_state <= WAIT;
        end
        WAIT: if (unit_done) begin
          r_jobs <= r_jobs + 16'd1;
          r_state <= CAPTURE;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
          if (r_tcnt + 1'b1 == TW'(TIMEOUT)) begin
            r_terr <= 1'b1;
            r_state <= IDLE;
          end
        end
        CAPTURE: if (!unit_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_dispatcher.sv
// tb_mult_dispatcher: random and directed stimulus against a queue-based reference and a behavioural core
module tb_mult_dispatcher;
  logic clk = 0, rst = 1, in_valid = 0, res_ready = 0, unit_done = 0;
  logic [15:0] in_a = 0, in_b = 0, unit_out = 0;
  logic in_ready, res_valid, unit_rst_begin, unit_start, busy, timeout_err;
  logic [15:0] res_data, unit_a, unit_b, jobs_done;
  int n_checks = 0, n_errors = 0;
  int n_acc = 0, n_drop = 0, n_start = 0, cyc = 0, last_start_cyc = 0;
  int st_run = 0, rb_run = 0, core_lat = 10, core_hold = 1, c_wait = 0, c_hold = 0;
  bit core_dead = 0, core_rand = 0, prev_rb = 0, prod_done = 0;
  logic [15:0] c_a = 0, c_b = 0;
  logic [15:0] exp_q [$];

  mult_dispatcher dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .unit_rst_begin(unit_rst_begin), .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_out(unit_out), .busy(busy), .timeout_err(timeout_err),
    .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural core: done after a latency, held for a number of cycles, out = a*b
  always @(posedge clk) begin
    if (rst) begin
      unit_done <= 0;
      c_wait <= 0;
      c_hold <= 0;
    end else if (unit_start) begin
      c_wait <= core_dead ? 0 : (core_rand ? int'($urandom_range(1, 12)) : core_lat);
      c_a <= unit_a;
      c_b <= unit_b;
    end else if (c_wait == 1) begin
      unit_done <= 1;
      unit_out <= c_a * c_b;
      c_hold <= core_rand ? int'($urandom_range(1, 3)) : core_hold;
      c_wait <= 0;
    end else if (c_wait > 1) c_wait <= c_wait - 1;
    else if (c_hold == 1) begin
      unit_done <= 0;
      unit_out <= 16'($urandom);
      c_hold <= 0;
    end else if (c_hold > 1) c_hold <= c_hold - 1;
  end

  // Reference scoreboard and protocol monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      n_acc = 0;
      n_drop = 0;
    end else begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("res_extra", 32'(exp_q.size()), 1);
        else chk("res_data", res_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(16'(in_a * in_b));
        n_acc++;
      end
    end
    if (unit_start) st_run++;
    else if (st_run > 0) begin
      chk("start_width", st_run, 1);
      st_run = 0;
    end
    if (unit_rst_begin) rb_run++;
    else if (rb_run > 0) begin
      chk("rst_begin_width", rb_run, 1);
      rb_run = 0;
    end
    if (unit_start && st_run == 1) begin
      n_start++;
      last_start_cyc = cyc;
      chk("rb_before_start", prev_rb, 1);
    end
    if (unit_done && busy) begin
      chk("unit_a_stable", unit_a, c_a);
      chk("unit_b_stable", unit_b, c_b);
    end
    prev_rb = unit_rst_begin;
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    bit ok = 0;
    @(posedge clk); #2;
    in_valid = 1; in_a = a; in_b = b;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("push_wait", in_ready, 1);
    @(posedge clk); #2;
    in_valid = 0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    chk({tag, "_drain"}, 32'(exp_q.size()), 0);
    chk({tag, "_jobs"}, jobs_done, 32'(16'(n_acc - n_drop)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, s0, n;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", unit_start, 0);
    chk("rst_rst_begin", unit_rst_begin, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_unit_b", unit_b, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_terr", timeout_err, 0);

    // Single job
    push(16'h0003, 16'hFFFE);
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge clk);
    chk("single_res", res_data, 16'hFFFA);
    chk("single_jobs", jobs_done, 1);
    @(posedge clk); #2 res_ready = 1;
    wait_drain("single");

    // Back-to-back while a long job occupies the core
    core_lat = 40;
    push(16'($urandom), 16'($urandom));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      in_valid = 1; in_a = 16'($urandom); in_b = 16'($urandom);
      @(negedge clk);
      chk("b2b_ready", in_ready, 1);
    end
    @(posedge clk); #2 in_a = 16'h1234;
    @(negedge clk);
    chk("b2b_full", in_ready, 0);
    @(posedge clk); #2 in_valid = 0;
    wait_drain("b2b");

    // Output backpressure: 6 jobs, only 4 result slots
    core_lat = 3;
    res_ready = 0;
    base = n_acc - n_drop;
    repeat (6) push(16'($urandom), 16'($urandom));
    repeat (80) @(negedge clk);
    s0 = n_start;
    repeat (20) @(negedge clk);
    chk("bp_no_start", n_start, s0);
    chk("bp_busy", busy, 0);
    chk("bp_valid", res_valid, 1);
    chk("bp_jobs", jobs_done, 32'(16'(base + 4)));
    @(posedge clk); #2 res_ready = 1;
    @(posedge clk); #2 res_ready = 0;
    for (int i = 0; i < 20 && n_start == s0; i++) @(negedge clk);
    chk("bp_resume", n_start, s0 + 1);
    res_ready = 1;
    wait_drain("bp");

    // Level-held done
    core_lat = 4;
    core_hold = 5;
    base = n_acc - n_drop;
    push(16'h0101, 16'h0202);
    for (int i = 0; i < 50 && !unit_done; i++) @(negedge clk);
    n = 0;
    for (int i = 0; i < 50 && unit_done; i++) begin
      @(negedge clk);
      n++;
    end
    chk("hold_cap_busy", busy, 1);
    @(negedge clk);
    chk("hold_cap_exit", busy, 0);
    chk("hold_jobs", jobs_done, 32'(16'(base + 1)));
    core_hold = 1;
    wait_drain("hold");

    // Timeout: first job never completes, second still issues
    core_dead = 1;
    base = n_acc - n_drop;
    push(16'h0007, 16'h0009);
    push(16'h0005, 16'h0006);
    for (int i = 0; i < 400 && !timeout_err; i++) @(negedge clk);
    chk("to_err", timeout_err, 1);
    chk("to_latency", cyc - last_start_cyc, 256);
    chk("to_no_result", res_valid, 0);
    chk("to_jobs", jobs_done, 32'(16'(base)));
    void'(exp_q.pop_front());
    n_drop++;
    core_dead = 0;
    s0 = n_start;
    for (int i = 0; i < 20 && n_start == s0; i++) @(negedge clk);
    chk("to_next", n_start, s0 + 1);
    wait_drain("to");
    chk("to_sticky", timeout_err, 1);

    // Randomized traffic with random core latency and backpressure
    core_rand = 1;
    fork
      begin
        for (int j = 0; j < 40; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          push(16'($urandom), 16'($urandom));
        end
        prod_done = 1;
      end
      begin
        for (int c = 0; c < 20000 && !(prod_done && exp_q.size() == 0); c++) begin
          @(posedge clk); #2;
          res_ready = 1'($urandom_range(0, 1));
        end
        res_ready = 1;
      end
    join
    core_rand = 0;
    wait_drain("rand");

    // Reset in the middle of a wait
    core_lat = 50;
    push(16'h0011, 16'h0022);
    repeat (8) @(negedge clk);
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_jobs", jobs_done, 0);
    chk("mid_rst_terr", timeout_err, 0);
    core_lat = 2;
    push(16'h0002, 16'h0003);
    wait_drain("post_rst");
    chk("post_rst_jobs1", jobs_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mult_dispatcher.md
Name: mult_dispatcher

Overview:
- Initiator-side sequencer for the start/done arithmetic unit (`top` core).
- Accepts a stream of signed operand pairs on a valid/ready input and queues them.
- Issues each pair to the core using the core's rst_begin/start/done protocol.
- Captures each core result into a result queue drained by a valid/ready output; sits between the system bus and the core instance.

Parameters:
- SIZE, 16, operand/result width (must match core SIZE)
- DEPTH, 4, entries in each of operand FIFO and result FIFO (power of two, >=2)
- TIMEOUT, 255, max cycles waited for unit_done before abort

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  operand FIFO not full
- in_a  input  SIZE  operand A
- in_b  input  SIZE  operand B
- res_valid  output  1  result FIFO not empty
- res_ready  input  1  downstream accepts result
- res_data  output  SIZE  head of result FIFO
- unit_rst_begin  output  1  one-cycle init pulse to core
- unit_start  output  1  one-cycle start pulse to core
- unit_a  output  SIZE  operand A to core, held stable IDLE->CAPTURE
- unit_b  output  SIZE  operand B to core, held stable IDLE->CAPTURE
- unit_done  input  1  core completion
- unit_out  input  SIZE  core result, valid while unit_done=1
- busy  output  1  FSM not in IDLE
- timeout_err  output  1  sticky: a job was aborted
- jobs_done  output  16  count of results captured, wraps at 0xFFFF

Behaviour:
- Reset (sync, rst=1 at posedge) values:
  - FSM to IDLE; both FIFOs empty.
  - in_ready=1, res_valid=0, unit_start=0, unit_rst_begin=0.
  - unit_a=unit_b=0, busy=0, timeout_err=0, jobs_done=0, timeout counter=0.
- Reset mid-job aborts silently: no result is pushed and the core is not signalled. The core itself is reset by the shared rst.
- Input handshake:
  - A push happens when in_valid && in_ready.
  - in_ready = !op_full.
  - Data is accepted the same cycle.
- Output handshake:
  - A pop happens when res_valid && res_ready.
  - res_data = result FIFO head, combinational from storage.
  - res_valid and res_data hold until the pop.
- FSM states:
  - IDLE: if !op_empty && result FIFO has a free slot (count < DEPTH), pop the operand FIFO, latch unit_a/unit_b, go to INIT. Otherwise stay.
  - INIT: unit_rst_begin=1 for exactly one cycle -> START.
  - START: unit_start=1 for exactly one cycle, clear the timeout counter -> WAIT.
  - WAIT:
    - If unit_done=1, push unit_out into the result FIFO in that same cycle, increment jobs_done -> CAPTURE.
    - Else increment the timeout counter. When it reaches TIMEOUT, set timeout_err -> IDLE with no push.
  - CAPTURE: wait until unit_done=0 (tolerates a level-held done) -> IDLE.
- Slot reservation: the free-slot check in IDLE guarantees the WAIT push never overflows, even if the downstream stalls.
- Simultaneous push/pop on either FIFO:
  - Both succeed; count is unchanged.
  - Pop when empty is ignored.
  - Push when full cannot occur (in_ready gating and the reservation above).
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Minimum job latency, from operand-FIFO pop to result visible on res_valid: 3 + core cycles + 1.
- unit_done arriving in IDLE, INIT or START is ignored.
- timeout_err clears only on rst.

Decomposition:
- Package mult_dispatcher_pkg:
  - FSM state encoding (IDLE, INIT, START, WAIT, CAPTURE).
  - Default SIZE/DEPTH/TIMEOUT constants.
  - Timeout counter width = clog2(TIMEOUT+1).
- Sub-module sync_fifo (params WIDTH, DEPTH; ports clk, rst, push, pop, din, dout, full, empty, count).
  - Instanced twice: operand FIFO (WIDTH=2*SIZE) and result FIFO (WIDTH=SIZE).
- The FSM and counters live in mult_dispatcher.

Test Plan:
- Single job:
  - Stimulus: push A=0x0003, B=0xFFFE; behavioural core model asserts done after 10 cycles with out=0xFFFA.
  - Required: rst_begin then start each pulse exactly 1 cycle; unit_a/unit_b stable throughout; res_data=0xFFFA; jobs_done=1.
- Back-to-back, no loss/reorder:
  - Stimulus: push 4 pairs in 4 consecutive cycles (DEPTH=4).
  - Required: in_ready stays 1 through the 4 pushes, drops to 0 only on a 5th attempt while full; 4 results emerge in order.
- Output backpressure:
  - Stimulus: res_ready=0 with 6 jobs queued.
  - Required: exactly 4 results held; FSM idles in IDLE with busy=0 and no unit_start until a pop, then the next job issues.
- Timeout:
  - Stimulus: core never asserts done, TIMEOUT=255.
  - Required: timeout_err=1 exactly 255 cycles after the WAIT entry; no result pushed; next queued job still issues.
- Level-held done:
  - Stimulus: core holds done=1 for 5 cycles.
  - Required: exactly one result pushed; FSM leaves CAPTURE the cycle after done falls.
- Reset mid-WAIT:
  - Stimulus: assert rst for 1 cycle.
  - Required: next cycle busy=0, res_valid=0, in_ready=1, jobs_done=0, timeout_err=0.
